// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised synchronous FIFO with FWFT option, watermark flags and sticky over/underflow
module sync_fifo_param #(
   parameter int DATA_W = 9,
   parameter int ADDR_W = 4,
   parameter bit FWFT   = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_request,
   input  logic              rd_request,
   input  logic              clear_overflow_request,
   input  logic              clear_underflow_request,
   input  logic [ADDR_W:0]   almost_full_level,
   input  logic [ADDR_W:0]   almost_empty_level,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow,
   output logic [ADDR_W:0]   wr_index,
   output logic [ADDR_W:0]   rd_index,
   output logic [ADDR_W:0]   watermark
);
   localparam int DEPTH = 1 << ADDR_W;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]   wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
   logic              ovf_q, ovf_d, unf_q, unf_d, rd_ok, wr_ok;
   logic [DATA_W-1:0] rd_data_q, rd_data_d, head;
   logic [ADDR_W:0]   one;
   // status decode, accept logic and next-state for pointers, flags and read register
   always_comb begin
      one          = {{ADDR_W{1'b0}}, 1'b1};
      head         = mem_q[rd_idx_q[ADDR_W-1:0]];
      empty        = wr_idx_q == rd_idx_q;
      full         = (wr_idx_q[ADDR_W-1:0] == rd_idx_q[ADDR_W-1:0]) && (wr_idx_q[ADDR_W] != rd_idx_q[ADDR_W]);
      watermark    = wr_idx_q - rd_idx_q;
      almost_full  = watermark >= almost_full_level;
      almost_empty = watermark <= almost_empty_level;
      rd_ok        = rd_request && !empty;
      wr_ok        = wr_request && (!full || rd_ok);
      wr_idx_d     = wr_ok ? wr_idx_q + one : wr_idx_q;
      rd_idx_d     = rd_ok ? rd_idx_q + one : rd_idx_q;
      ovf_d        = (wr_request && !wr_ok) || (ovf_q && !clear_overflow_request);
      unf_d        = (rd_request && !rd_ok) || (unf_q && !clear_underflow_request);
      rd_data_d    = rd_ok ? head : rd_data_q;
      rd_data      = FWFT ? head : rd_data_q;
   end
   assign wr_index  = wr_idx_q;
   assign rd_index  = rd_idx_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   // state registers; synchronous active-low reset overrides any transfer
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         rd_data_q <= rd_data_d;
      end
   end
   // storage array, not reset; writes suppressed while reset is asserted
   always_ff @(posedge clk) begin
      if (reset && wr_ok) mem_q[wr_idx_q[ADDR_W-1:0]] <= wr_data;
   end
endmodule
